lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter AWIDTH, default 10, word-address width of the attached data memory (2^AWIDTH 32-bit words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  execute stage presents a load/store.
REQ-005 req_ready  output  1  request accepted on edge where req_valid&&req_ready.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RV32I funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU (loads); 0/1/2 (stores).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, LSB-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-011 resp_rdata  output  32  formatted load result; 0 for stores and errors.
REQ-012 resp_err  output  1  illegal funct3, qualified by resp_valid.
REQ-013 mem_en / mem_we  output  1 / 1  memory access strobe / write enable.
REQ-014 mem_addr  output  AWIDTH  word address.
REQ-015 mem_wdata / mem_wstrb  output  32 / 4  lane-shifted store data / byte-lane enables.
REQ-016 mem_rdata  input  32  read word, valid the cycle after mem_en&&!mem_we (1-cycle latency).

Function
REQ-017 FSM states IDLE, ACC0, ACC1, RESP; req_ready=1 only in IDLE.
REQ-018 Accept in IDLE: capture we/funct3/addr/wdata; legal -> ACC0, illegal funct3 (load 3,6,7; store >2) -> RESP with resp_err=1, no memory access.
REQ-019 Split access when W with addr[1:0]!=0, or H/HU with addr[1:0]==3; otherwise single.
REQ-020 ACC0: mem_en=1, mem_addr=addr[AWIDTH+1:2]; -> ACC1 if split else RESP.
REQ-021 ACC1: mem_en=1, mem_addr=previous word+1 modulo 2^AWIDTH (wrap); word0 from mem_rdata captured into buffer; -> RESP.
REQ-022 RESP: resp_valid=1 for exactly one cycle; -> IDLE.
REQ-023 Latency accept-edge to resp_valid cycle: single 2 cycles, split 3, illegal 1; max throughput one request per 3 cycles.
REQ-024 Store lanes: data shifted left by 8*addr[1:0]; strobes B 1<<a, H 0011<<a, W 1111<<a (a=addr[1:0]); bits beyond lane 3 go to ACC1 word at lanes 0..
REQ-025 Load format in RESP from {mem_rdata,buffer} (split) or mem_rdata (single), shifted right by 8*a; B/H sign-extend, BU/HU zero-extend, W unchanged; little-endian.
REQ-026 Memory outputs 0 in IDLE and RESP; mem_wdata/mem_wstrb 0 when mem_we=0.

Reset
REQ-027 rst low: state IDLE immediately, all outputs 0 including req_ready, buffer cleared.
REQ-028 rst asserted mid-operation aborts access; no resp_valid for the aborted request; req_ready=1 first cycle after release.

Structure
REQ-029 Shared package rv32i_pkg holds funct3 load/store constants and the lsu state enum.
REQ-030 One combinational sub-module lsu_load_align (shift, sign/zero extend); strobe/shift logic stays inline.

Verification
REQ-031 SW 0x8 data 0xDEADBEEF -> one write word 2 strobe 1111; LW 0x8 -> resp_rdata 0xDEADBEEF 2 cycles after accept.
REQ-032 Word2=0xDEADBEEF: LB 0x9 -> 0xFFFFFFBE; LBU 0x9 -> 0x000000BE; LHU 0xA -> 0x0000DEAD.
REQ-033 Word1=0x44332211, word2=0x88776655: LW 0x6 -> reads words 1,2, resp_rdata 0x66554433 at 3 cycles.
REQ-034 SH 0xFFF data 0x1234 -> word 1023 strobe 1000 data 0x34000000, then word 0 strobe 0001 data 0x00000012.
REQ-035 Load funct3=3 -> no mem_en, resp_valid next cycle with resp_err=1, resp_rdata 0.
REQ-036 rst low during ACC1 -> mem_en 0 same cycle, no resp_valid; after release new LW completes normally.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU state type and
// small helpers for lane masks and split detection.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_ACC0 = 2'd1,
    LSU_ACC1 = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // size is funct3[1:0]: 0 byte, 1 half, 2 word
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic needs_split(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'd2) && (off != 2'd0)) || ((size == 2'd1) && (off == 2'd3));
  endfunction

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// Load result formatting: byte-shift a (possibly two-word) little-endian
// window down by the address offset, then sign- or zero-extend.
module lsu_load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [63:0] raw,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = 32'(raw >> {offset, 3'b000});
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata = shifted;
      F3_BU:   rdata = {24'b0, shifted[7:0]};
      F3_HU:   rdata = {16'b0, shifted[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, misaligned word/half
// accesses split into two consecutive word accesses with address wrap.
module lsu_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state;
  logic              we_q;
  logic              err_q;
  logic              split_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [AWIDTH-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [63:0]       st_data;
  logic [7:0]        st_strb;
  logic [63:0]       ld_raw;
  logic [31:0]       ld_data;
  logic              unused_addr_hi;

  // Byte address bits above the attached memory simply alias.
  assign unused_addr_hi = ^req_addr[31:AWIDTH+2];

  // Gated by rst so the handshake is low while reset is held.
  assign req_ready = rst && (state == LSU_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= LSU_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            off_q   <= req_addr[1:0];
            waddr_q <= req_addr[AWIDTH+1:2];
            wdata_q <= req_wdata;
            err_q   <= !f3_legal(req_we, req_funct3);
            split_q <= needs_split(req_funct3[1:0], req_addr[1:0]);
            state   <= f3_legal(req_we, req_funct3) ? LSU_ACC0 : LSU_RESP;
          end
        end
        LSU_ACC0: state <= split_q ? LSU_ACC1 : LSU_RESP;
        LSU_ACC1: begin
          buf_q <= mem_rdata;
          state <= LSU_RESP;
        end
        default:  state <= LSU_IDLE;
      endcase
    end
  end

  // Store bytes/strobes spilling past lane 3 land in the second word.
  assign st_data = {32'b0, wdata_q} << {off_q, 3'b000};
  assign st_strb = {4'b0, lane_mask(f3_q[1:0])} << off_q;
  assign ld_raw  = split_q ? {mem_rdata, buf_q} : {32'b0, mem_rdata};

  lsu_load_align u_align (
    .funct3 (f3_q),
    .offset (off_q),
    .raw    (ld_raw),
    .rdata  (ld_data)
  );

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state)
      LSU_ACC0: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        mem_addr = waddr_q;
        if (we_q) begin
          mem_wdata = st_data[31:0];
          mem_wstrb = st_strb[3:0];
        end
      end
      LSU_ACC1: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        mem_addr = waddr_q + AWIDTH'(1);
        if (we_q) begin
          mem_wdata = st_data[63:32];
          mem_wstrb = st_strb[7:4];
        end
      end
      LSU_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? '0 : ld_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: table of load/store vectors against a 1-cycle memory
// model, scoreboard of expected responses, plus reset and split sequences.
module tb_lsu_ctrl;

  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata;

  lsu_ctrl #(.AWIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    string       nm;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned lat;
    int unsigned nacc;
    logic [9:0]  addr0;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned start;
  } exp_t;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } acc_t;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  exp_t        sb[$];
  acc_t        mem_log[$];
  vec_t        tbl[$];
  logic [31:0] mem [0:1023];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: sample the bus at negedge, act on the next posedge,
  // read data appears 1 time unit after that edge.
  initial begin
    acc_t a;
    logic en_s;
    for (int unsigned i = 0; i < 1024; i++) mem[i] = '0;
    mem[1] = 32'h44332211;
    mem[2] = 32'h88776655;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      en_s    = rst && mem_en;
      a.we    = mem_we;
      a.addr  = mem_addr;
      a.wdata = mem_wdata;
      a.strb  = mem_wstrb;
      if (en_s) mem_log.push_back(a);
      @(posedge clk);
      #1;
      if (en_s && !a.we) mem_rdata = mem[a.addr];
      if (en_s && a.we)
        for (int b = 0; b < 4; b++)
          if (a.strb[b]) mem[a.addr][8*b +: 8] = a.wdata[8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int unsigned lat, input int unsigned nacc,
                     input logic [9:0] addr0);
    vec_t v;
    v.nm = nm; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat;
    v.nacc = nacc; v.addr0 = addr0;
    tbl.push_back(v);
  endtask

  task automatic issue(input vec_t v);
    exp_t        e;
    int unsigned base;
    int unsigned n;
    logic        got;
    base = mem_log.size();
    @(negedge clk);
    req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({v.nm, "_ready"}, {31'b0, req_ready}, 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: v.lat, start: cyc});
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (resp_valid) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          chk({v.nm, "_unexpected_resp"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({v.nm, "_rdata"}, resp_rdata, e.rdata);
          chk({v.nm, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
          chk({v.nm, "_latency"}, cyc - e.start, e.lat);
        end
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_resp required=resp_valid", v.nm);
      sb.delete();
    end
    @(negedge clk);
    chk({v.nm, "_single_pulse"}, {31'b0, resp_valid}, 32'd0);
    chk({v.nm, "_naccess"}, mem_log.size() - base, v.nacc);
    if (v.nacc > 0 && mem_log.size() > base) begin
      chk({v.nm, "_addr0"}, {22'b0, mem_log[base].addr}, {22'b0, v.addr0});
      chk({v.nm, "_we"}, {31'b0, mem_log[base].we}, {31'b0, v.we});
    end
    if (v.nacc == 2 && mem_log.size() > base + 1)
      chk({v.nm, "_addr1"}, {22'b0, mem_log[base+1].addr}, {22'b0, 10'(v.addr0 + 10'd1)});
  endtask

  task automatic check_log(input string nm, input int unsigned idx, input logic [9:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    if (idx >= mem_log.size()) begin
      chk({nm, "_present"}, 32'd0, 32'd1);
      return;
    end
    chk({nm, "_we"},    {31'b0, mem_log[idx].we}, 32'd1);
    chk({nm, "_addr"},  {22'b0, mem_log[idx].addr}, {22'b0, addr});
    chk({nm, "_wdata"}, mem_log[idx].wdata, wdata);
    chk({nm, "_wstrb"}, {28'b0, mem_log[idx].strb}, {28'b0, strb});
  endtask

  initial begin
    int unsigned base;
    logic        seen;
    vec_t        v;
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h8; req_wdata = '0;

    // Words 1/2 preloaded as 0x44332211 / 0x88776655
    add("lw_4",      1'b0, 3'd2, 32'h004, 32'h0,        32'h44332211, 1'b0, 2, 1, 10'd1);
    add("lw_6",      1'b0, 3'd2, 32'h006, 32'h0,        32'h66554433, 1'b0, 3, 2, 10'd1);
    add("lh_6",      1'b0, 3'd1, 32'h006, 32'h0,        32'h00004433, 1'b0, 2, 1, 10'd1);
    add("lb_7",      1'b0, 3'd0, 32'h007, 32'h0,        32'h00000044, 1'b0, 2, 1, 10'd1);
    add("lhu_7",     1'b0, 3'd5, 32'h007, 32'h0,        32'h00005544, 1'b0, 3, 2, 10'd1);
    add("lb_b",      1'b0, 3'd0, 32'h00B, 32'h0,        32'hFFFFFF88, 1'b0, 2, 1, 10'd2);
    add("lh_a",      1'b0, 3'd1, 32'h00A, 32'h0,        32'hFFFF8877, 1'b0, 2, 1, 10'd2);
    add("ld_f3_3",   1'b0, 3'd3, 32'h008, 32'h0,        32'h00000000, 1'b1, 1, 0, 10'd0);
    add("ld_f3_6",   1'b0, 3'd6, 32'h008, 32'h0,        32'h00000000, 1'b1, 1, 0, 10'd0);
    add("st_f3_4",   1'b1, 3'd4, 32'h008, 32'h12345678, 32'h00000000, 1'b1, 1, 0, 10'd0);
    // After SW 0x8 and SH 0xFFF: word2 DEADBEEF, word1023 34000000, word0 12
    add("lw_8",      1'b0, 3'd2, 32'h008, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 10'd2);
    add("lb_9",      1'b0, 3'd0, 32'h009, 32'h0,        32'hFFFFFFBE, 1'b0, 2, 1, 10'd2);
    add("lbu_9",     1'b0, 3'd4, 32'h009, 32'h0,        32'h000000BE, 1'b0, 2, 1, 10'd2);
    add("lhu_a",     1'b0, 3'd5, 32'h00A, 32'h0,        32'h0000DEAD, 1'b0, 2, 1, 10'd2);
    add("lh_9",      1'b0, 3'd1, 32'h009, 32'h0,        32'hFFFFADBE, 1'b0, 2, 1, 10'd2);
    add("lw_ffd",    1'b0, 3'd2, 32'hFFD, 32'h0,        32'h12340000, 1'b0, 3, 2, 10'd1023);
    add("lbu_fff",   1'b0, 3'd4, 32'hFFF, 32'h0,        32'h00000034, 1'b0, 2, 1, 10'd1023);
    add("sb_5",      1'b1, 3'd0, 32'h005, 32'hFFFFFFAB, 32'h00000000, 1'b0, 2, 1, 10'd1);
    add("lw_4_post", 1'b0, 3'd2, 32'h004, 32'h0,        32'h4433AB11, 1'b0, 2, 1, 10'd1);
    add("lw_alias",  1'b0, 3'd2, 32'h1008, 32'h0,       32'hDEADBEEF, 1'b0, 2, 1, 10'd2);

    repeat (3) @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
    chk("reset_outputs_or", {31'b0, |{resp_valid, resp_err, resp_rdata, mem_en, mem_we,
                                       mem_addr, mem_wdata, mem_wstrb}}, 32'd0);
    rst = 1'b1;
    req_valid = 1'b0;
    #1 chk("release_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 10; i++) issue(tbl[i]);

    base = mem_log.size();
    v.nm = "sw_8"; v.we = 1'b1; v.f3 = 3'd2; v.addr = 32'h8; v.wdata = 32'hDEADBEEF;
    v.exp_rdata = '0; v.exp_err = 1'b0; v.lat = 2; v.nacc = 1; v.addr0 = 10'd2;
    issue(v);
    check_log("sw_8_bus", base, 10'd2, 32'hDEADBEEF, 4'b1111);

    base = mem_log.size();
    v.nm = "sh_fff"; v.we = 1'b1; v.f3 = 3'd1; v.addr = 32'hFFF; v.wdata = 32'h00001234;
    v.exp_rdata = '0; v.exp_err = 1'b0; v.lat = 3; v.nacc = 2; v.addr0 = 10'd1023;
    issue(v);
    check_log("sh_fff_w0", base, 10'd1023, 32'h34000000, 4'b1000);
    check_log("sh_fff_w1", base + 1, 10'd0, 32'h00000012, 4'b0001);

    for (int i = 10; i < tbl.size(); i++) issue(tbl[i]);

    // Reset during the second half of a split load aborts it silently
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h6; req_valid = 1'b1;
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_acc0_en", {31'b0, mem_en}, 32'd1);
    @(negedge clk);
    chk("abort_acc1_en", {31'b0, mem_en}, 32'd1);
    chk("abort_acc1_addr", {22'b0, mem_addr}, 32'd2);
    rst = 1'b0;
    #1;
    chk("abort_mem_en", {31'b0, mem_en}, 32'd0);
    chk("abort_outputs_or", {31'b0, |{req_ready, resp_valid, resp_err, resp_rdata, mem_we,
                                       mem_addr, mem_wdata, mem_wstrb}}, 32'd0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    rst = 1'b1;
    #1 chk("abort_release_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("abort_no_resp", {31'b0, seen}, 32'd0);

    v.nm = "lw_after_abort"; v.we = 1'b0; v.f3 = 3'd2; v.addr = 32'h8; v.wdata = '0;
    v.exp_rdata = 32'hDEADBEEF; v.exp_err = 1'b0; v.lat = 2; v.nacc = 1; v.addr0 = 10'd2;
    issue(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
